// File: rtl/nr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nr_pkg
//  Description : Shared constants and types for the Newton-Raphson reciprocal:
//                datapath width, 16-entry seed table and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nr_pkg;

   localparam int c_W      = 24;
   localparam int c_SEED_N = 16;

   // seed[i] = round(2^24 * 16 / (17 + i)): reciprocal of the upper end of
   // the i-th 1/16 mantissa interval, so the seed always under-estimates.
   // Index 15 is listed first (leftmost element of the packed array).
   localparam logic [c_SEED_N-1:0][c_W-1:0] c_SEED_TABLE = {
      24'h800000,   // 15
      24'h842108,   // 14
      24'h888889,   // 13
      24'h8D3DCB,   // 12
      24'h924925,   // 11
      24'h97B426,   // 10
      24'h9D89D9,   //  9
      24'hA3D70A,   //  8
      24'hAAAAAB,   //  7
      24'hB21643,   //  6
      24'hBA2E8C,   //  5
      24'hC30C31,   //  4
      24'hCCCCCD,   //  3
      24'hD79436,   //  2
      24'hE38E39,   //  1
      24'hF0F0F1    //  0
   };

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEED = 3'd1,
      MULP = 3'd2,
      MULR = 3'd3,
      DONE = 3'd4
   } nr_state_t;

endpackage
`default_nettype wire

// File: rtl/nr_seed_rom.sv
`default_nettype none
// ============================================================================
//  Module      : nr_seed_rom
//  Description : Combinational 16 x 24-bit seed lookup, indexed by the four
//                mantissa bits just below the leading one.
//  Revision    : 1.0 - initial release
// ============================================================================
module nr_seed_rom
   import nr_pkg::*;
(
   input  logic [3:0]     i_idx,
   output logic [c_W-1:0] o_seed
);

   // plain table lookup
   always_comb begin
      o_seed = c_SEED_TABLE[i_idx];
   end

endmodule
`default_nettype wire

// File: rtl/nr_recip.sv
`default_nettype none
// ============================================================================
//  Module      : nr_recip
//  Description : Iterative Newton-Raphson reciprocal of a normalized Q1.23
//                mantissa, result in Q0.24. One 24x25 multiplier is shared
//                between the d*r (MULP) and r*(2-d*r) (MULR) steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module nr_recip
   import nr_pkg::*;
#(
   parameter int ITER = 3,
   parameter int W    = 24
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         out_err
);

   localparam int                 c_CNT_W     = 3;
   localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(ITER - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [W-1:0]       c_SAT       = {W{1'b1}};
   localparam logic [W:0]         c_T_ZERO    = '0;

   nr_state_t          r_state;
   nr_state_t          w_state_nxt;

   logic [W-1:0]       r_d;
   logic [W-1:0]       r_r;
   logic [W:0]         r_t;
   logic               r_err;
   logic [c_CNT_W-1:0] r_iter;

   logic               r_out_valid;
   logic [W-1:0]       r_out_r;
   logic               r_out_err;

   logic               w_accept;
   logic [W-1:0]       w_seed;
   logic [W-1:0]       w_mul_a;
   logic [W:0]         w_mul_b;
   logic [2*W:0]       w_prod;
   logic               w_unused_prod_lsb;

   nr_seed_rom u_seed_rom (
      .i_idx  (r_d[W-2:W-5]),
      .o_seed (w_seed)
   );

   // Shared multiplier: d*r in MULP (Q1.47 in 48 bits), r*t in MULR (Q1.48)
   assign w_mul_a = (r_state == MULR) ? r_r : r_d;
   assign w_mul_b = (r_state == MULR) ? r_t : {1'b0, r_r};
   assign w_prod  = {{(W+1){1'b0}}, w_mul_a} * {{W{1'b0}}, w_mul_b};

   // Low product bits fall below the Q1.24 truncation point
   assign w_unused_prod_lsb = ^w_prod[W-2:0];

   assign w_accept  = in_valid & in_ready;
   assign out_valid = r_out_valid;
   assign out_r     = r_out_r;
   assign out_err   = r_out_err;

   // FSM state register; reset abandons any computation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid && !rst) begin
               w_state_nxt = SEED;
            end
         end
         SEED:    w_state_nxt = MULP;
         MULP:    w_state_nxt = MULR;
         MULR:    w_state_nxt = (r_iter == c_LAST_ITER) ? DONE : MULP;
         DONE: begin
            // leave only once the registered result has been taken
            if (r_out_valid && out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture and Newton-Raphson iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d    <= '0;
         r_r    <= '0;
         r_t    <= '0;
         r_err  <= 1'b0;
         r_iter <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_d   <= in_d;
                  r_err <= ~in_d[W-1];
               end
            end
            SEED: begin
               r_r    <= w_seed;
               r_iter <= '0;
            end
            MULP: begin
               // t = 2 - d*r, with d*r truncated to Q1.24 (mod 2^25)
               r_t <= c_T_ZERO - w_prod[2*W-1:W-1];
            end
            MULR: begin
               r_r    <= w_prod[2*W] ? c_SAT : w_prod[2*W-1:W];
               r_iter <= r_iter + c_CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Output register: first DONE cycle loads the result, valid holds until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_err   <= 1'b0;
      end else if (r_state == DONE) begin
         if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_r     <= r_err ? c_SAT : r_r;
            r_out_err   <= r_err;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nr_recip.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nr_recip
//  Description : Directed and random self-checking bench for nr_recip.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nr_recip;

   localparam int ITER   = 3;
   localparam int W      = 24;
   localparam int LAT    = 2 + 2*ITER;
   localparam int N_RAND = 1500;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_d;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_r;
   logic         out_err;

   int n_checks  = 0;
   int n_fail    = 0;
   int n_results = 0;

   nr_recip #(.ITER(ITER), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_d      (in_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] lo, input logic [31:0] hi);
      n_checks++;
      if (obs < lo || obs > hi) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h..0x%0h", tag, obs, lo, hi);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      check("in_ready_before_send", 32'(in_ready), 32'd1, 32'd1);
      in_valid = 1'b1;
      in_d     = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_one(input string tag, input logic [W-1:0] d,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input logic err);
      int lat;
      send(d);
      wait_valid(lat);
      check({tag, "_lat"}, 32'(lat), 32'(LAT), 32'(LAT));
      check({tag, "_r"}, 32'(out_r), lo, hi);
      check({tag, "_err"}, 32'(out_err), 32'(err), 32'(err));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1, 32'd1);
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  saw_valid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_d      = '0;
      out_ready = 1'b0;

      // reset state
      tick();
      tick();
      check("rst_in_ready",  32'(in_ready),  32'd0, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0, 32'd0);
      check("rst_out_r",     32'(out_r),     32'd0, 32'd0);
      check("rst_out_err",   32'(out_err),   32'd0, 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", 32'(in_ready), 32'd1, 32'd1);

      // reset wins over a simultaneous in_valid
      rst      = 1'b1;
      in_valid = 1'b1;
      in_d     = 24'hC00000;
      tick();
      tick();
      check("rst_vs_valid_in_ready", 32'(in_ready), 32'd0, 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_valid |= out_valid;
      end
      check("rst_vs_valid_no_result", 32'(saw_valid), 32'd0, 32'd0);
      check("rst_vs_valid_idle", 32'(in_ready), 32'd1, 32'd1);

      // directed values
      run_one("d1p5",   24'hC00000, 32'hAAAAAA, 32'hAAAAAB, 1'b0);
      run_one("d1p0",   24'h800000, 32'hFFFFFF, 32'hFFFFFF, 1'b0);
      run_one("dmax",   24'hFFFFFF, 32'h7FFFFF, 32'h800001, 1'b0);
      run_one("denorm", 24'h400000, 32'hFFFFFF, 32'hFFFFFF, 1'b1);

      // backpressure in DONE with a stray in_valid pulse
      send(24'hE00000);
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'(LAT), 32'(LAT));
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1, 32'd1);
         check("bp_in_ready",  32'(in_ready),  32'd0, 32'd0);
         check("bp_out_r",     32'(out_r),     32'h924922, 32'h924926);
         check("bp_out_err",   32'(out_err),   32'd0, 32'd0);
         in_valid = (i == 2);
         in_d     = 24'h800000;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_idle_next", 32'(in_ready), 32'd1, 32'd1);
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_valid |= out_valid;
      end
      check("bp_no_capture", 32'(saw_valid), 32'd0, 32'd0);

      // reset during MULP of the second iteration
      send(24'hC00000);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         saw_valid |= out_valid;
      end
      check("midrst_no_valid", 32'(saw_valid), 32'd0, 32'd0);
      run_one("recover_1p25", 24'hA00000, 32'hCCCCCC, 32'hCCCCCD, 1'b0);

      // random back-to-back sweep with random out_ready
      for (int i = 0; i < N_RAND; i++) begin
         logic [31:0]     rnd;
         logic [W-1:0]    d;
         longint unsigned ref_q;
         logic [31:0]     lo;
         logic [31:0]     hi;
         int              rlat;
         bit              got;
         int              k;
         rnd   = $urandom();
         d     = {1'b1, rnd[W-2:0]};
         ref_q = (64'd1 << 47) / {40'd0, d};
         if (ref_q > 64'hFFFFFF) ref_q = 64'hFFFFFF;
         lo = (ref_q >= 64'd2) ? 32'(ref_q - 64'd2) : 32'd0;
         hi = (ref_q + 64'd2 > 64'hFFFFFF) ? 32'hFFFFFF : 32'(ref_q + 64'd2);
         send(d);
         wait_valid(rlat);
         if (out_valid) n_results++;
         check("rand_lat", 32'(rlat), 32'(LAT), 32'(LAT));
         check("rand_r",   32'(out_r), lo, hi);
         check("rand_err", 32'(out_err), 32'd0, 32'd0);
         got = 1'b0;
         k   = 0;
         while (!got && k < 64) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
            if (out_ready) got = 1'b1;
         end
         out_ready = 1'b0;
         check("rand_no_dup", 32'(out_valid), 32'd0, 32'd0);
      end
      check("rand_count", 32'(n_results), 32'(N_RAND), 32'(N_RAND));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
